// File: rtl/data_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : data_cache_controller
// Purpose  : Direct-mapped, write-through, no-write-allocate data cache with
//            4-word lines, a single-cycle CPU port and a request/ack memory port.
// Options  : CACHE_STATS_EN enables the HitCount/MissCount statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module data_cache_controller #(
  parameter int INDEX_BITS = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
);

  localparam int c_NUM_LINES = 1 << INDEX_BITS;
  localparam int c_TAG_BITS  = 32 - INDEX_BITS - 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [c_NUM_LINES-1:0]  r_valid;
  logic [c_TAG_BITS-1:0]   r_tag  [c_NUM_LINES];
  logic [31:0]             r_data [c_NUM_LINES][4];
  logic [1:0]              r_cnt;
  logic [31:2]             r_addr;
  logic [31:0]             r_wdata;

  logic [c_TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0]   w_index;
  logic [1:0]              w_word;
  logic                    w_hit;
  logic [c_TAG_BITS-1:0]   w_l_tag;
  logic [INDEX_BITS-1:0]   w_l_index;
  logic                    w_unused;

  assign w_tag     = ALUResult[31:INDEX_BITS+4];
  assign w_index   = ALUResult[INDEX_BITS+3:4];
  assign w_word    = ALUResult[3:2];
  assign w_hit     = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_l_tag   = r_addr[31:INDEX_BITS+4];
  assign w_l_index = r_addr[INDEX_BITS+3:4];
  assign w_unused  = ^ALUResult[1:0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_cnt   <= 2'd0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MemWrite) begin
            r_state <= S_WRITE;
            r_addr  <= ALUResult[31:2];
            r_wdata <= WriteData;
          end else if (MemRead && !w_hit) begin
            // The victim line is invalidated up front so a half-written line
            // can never be mistaken for the old contents.
            r_state          <= S_FILL;
            r_cnt            <= 2'd0;
            r_addr           <= ALUResult[31:2];
            r_valid[w_index] <= 1'b0;
          end
        end
        S_FILL: begin
          if (MemAck) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_valid[w_l_index] <= 1'b1;
              r_state            <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          if (MemAck) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data and tag storage carry no reset; validity alone qualifies them.
  always_ff @(posedge CLK) begin
    if (r_state == S_IDLE && MemWrite && w_hit) begin
      r_data[w_index][w_word] <= WriteData;
    end
    if (r_state == S_FILL && MemAck) begin
      r_data[w_l_index][r_cnt] <= MemRData;
      if (r_cnt == 2'd3) begin
        r_tag[w_l_index] <= w_l_tag;
      end
    end
  end

  // Outputs are gated by reset so that a mid-transaction reset drops them at once.
  always_comb begin
    ReadData = 32'd0;
    Stall    = 1'b0;
    MemReq   = 1'b0;
    MemWe    = 1'b0;
    MemAddr  = 32'd0;
    MemWData = 32'd0;
    if (RST) begin
      case (r_state)
        S_IDLE: begin
          if (MemWrite) begin
            Stall = 1'b1;
          end else if (MemRead) begin
            if (w_hit) begin
              ReadData = r_data[w_index][w_word];
            end else begin
              Stall = 1'b1;
            end
          end
        end
        S_FILL: begin
          MemReq  = 1'b1;
          Stall   = 1'b1;
          MemAddr = {r_addr[31:4], r_cnt, 2'b00};
        end
        S_WRITE: begin
          MemReq   = 1'b1;
          MemWe    = 1'b1;
          MemAddr  = {r_addr[31:2], 2'b00};
          MemWData = r_wdata;
          Stall    = ~MemAck;
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else if (r_state == S_IDLE && MemRead && !MemWrite) begin
      if (w_hit) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign HitCount  = r_hit_cnt;
  assign MissCount = r_miss_cnt;
`else
  assign HitCount  = 32'd0;
  assign MissCount = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_cache_controller
// Purpose  : Self-checking bench for data_cache_controller: directed scenarios
//            plus randomized traffic against a behavioural cache model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache_controller;

  localparam logic [31:0] c_K = 32'hA5A5_A5A5;
`ifdef CACHE_STATS_EN
  localparam bit c_STATS = 1'b1;
`else
  localparam bit c_STATS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] ALUResult = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] ReadData;
  logic        Stall;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData = 32'd0;
  logic        MemAck = 1'b0;
  logic [31:0] HitCount;
  logic [31:0] MissCount;

  data_cache_controller #(.INDEX_BITS(5)) dut (
    .CLK(CLK), .RST(RST), .ALUResult(ALUResult), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData), .Stall(Stall),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck), .HitCount(HitCount), .MissCount(MissCount)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, exp, $time);
  endfunction

  // ---------------- memory responder ----------------
  bit rand_n   = 1'b0;
  bit ack_noise = 1'b0;
  int req_cnt  = 0;
  int cur_n    = 2;

  always begin
    @(posedge CLK);
    #2;
    if (RST && MemReq) begin
      if (req_cnt == 0) cur_n = rand_n ? int'($urandom_range(1, 3)) : 2;
      req_cnt++;
      if (req_cnt >= cur_n) begin
        MemAck   = 1'b1;
        MemRData = MemAddr ^ c_K;
        req_cnt  = 0;
      end else begin
        MemAck   = 1'b0;
        MemRData = $urandom;
      end
    end else begin
      req_cnt  = 0;
      MemAck   = ack_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      MemRData = $urandom;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef enum int {MD_IDLE, MD_FILL, MD_WRITE} mode_t;
  mode_t       m_mode = MD_IDLE;
  logic [31:0] m_word [logic [31:0]];   // cached contents by word address
  logic [27:0] m_owner [32];            // line address resident at each index
  bit          m_ownv [32];
  logic [31:0] m_base, m_waddr, m_wdata;
  int          m_k;
  logic [31:0] m_hits = 0, m_misses = 0;
  logic [31:0] fill_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] wrd_q[$];

  logic [31:0] e_rd, e_addr, e_wd, wa;
  logic        e_st, e_req, e_we;
  bit          chk_wd;
  int          idx;

  always @(negedge CLK) begin
    e_rd = 0; e_st = 0; e_req = 0; e_we = 0; e_addr = 0; e_wd = 0; chk_wd = 1;
    if (!RST) begin
      m_mode = MD_IDLE;
      for (int i = 0; i < 32; i++) m_ownv[i] = 0;
      m_hits = 0;
      m_misses = 0;
    end
    chk("HitCount",  HitCount,  c_STATS ? m_hits   : 32'd0);
    chk("MissCount", MissCount, c_STATS ? m_misses : 32'd0);
    if (RST) begin
      idx = int'(ALUResult[8:4]);
      wa  = {ALUResult[31:2], 2'b00};
      case (m_mode)
        MD_IDLE: begin
          if (MemWrite) begin
            e_st = 1;
            if (m_ownv[idx] && m_owner[idx] == ALUResult[31:4]) m_word[wa] = WriteData;
            m_waddr = wa;
            m_wdata = WriteData;
            m_mode  = MD_WRITE;
          end else if (MemRead) begin
            if (m_ownv[idx] && m_owner[idx] == ALUResult[31:4]) begin
              e_rd = m_word[wa];
              m_hits++;
            end else begin
              e_st = 1;
              m_misses++;
              m_base = {ALUResult[31:4], 4'h0};
              m_k = 0;
              m_ownv[idx] = 0;
              m_mode = MD_FILL;
            end
          end
        end
        MD_FILL: begin
          e_req = 1; e_st = 1; chk_wd = 0;
          e_addr = m_base + 32'(4 * m_k);
          if (MemAck) begin
            m_word[e_addr] = MemRData;
            fill_q.push_back(e_addr);
            m_k++;
            if (m_k == 4) begin
              m_owner[int'(m_base[8:4])] = m_base[31:4];
              m_ownv[int'(m_base[8:4])]  = 1;
              m_mode = MD_IDLE;
            end
          end
        end
        default: begin
          e_req = 1; e_we = 1; e_addr = m_waddr; e_wd = m_wdata;
          e_st = !MemAck;
          if (MemAck) begin
            wr_q.push_back(m_waddr);
            wrd_q.push_back(m_wdata);
            m_mode = MD_IDLE;
          end
        end
      endcase
    end
    chk("ReadData", ReadData, e_rd);
    chk("Stall",    32'(Stall),  32'(e_st));
    chk("MemReq",   32'(MemReq), 32'(e_req));
    chk("MemWe",    32'(MemWe),  32'(e_we));
    chk("MemAddr",  MemAddr, e_addr);
    if (chk_wd) chk("MemWData", MemWData, e_wd);
  end

  // ---------------- CPU driver ----------------
  task automatic do_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       output int stalls, output logic [31:0] rd);
    @(posedge CLK); #1;
    MemRead = !wr; MemWrite = wr; ALUResult = a; WriteData = d;
    stalls = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      #1;
      if (!Stall) break;
      stalls++;
    end
    if (Stall) chk("op_timeout", 32'(Stall), 32'd0);
    rd = ReadData;
  endtask

  task automatic go_idle(input int n);
    @(posedge CLK); #1;
    MemRead = 0; MemWrite = 0;
    repeat (n) @(negedge CLK);
    #1;
  endtask

  int          st;
  logic [31:0] rd;

  initial begin
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;

    // Cold miss then hits
    fill_q.delete();
    do_op(0, 32'h0000_1100, 0, st, rd);
    chk("miss1_stall_cycles", 32'(st), 32'd9);
    chk("miss1_data", rd, 32'hA5A5_B4A5);
    chk("fill_count", 32'(fill_q.size()), 32'd4);
    for (int i = 0; i < fill_q.size() && i < 4; i++)
      chk("fill_addr_seq", fill_q[i], 32'h0000_1100 + 32'(4 * i));
    do_op(0, 32'h0000_1108, 0, st, rd);
    chk("hit1108_stall", 32'(st), 32'd0);
    chk("hit1108_data", rd, 32'hA5A5_B4AD);
    go_idle(1);
    chk("stats_hits", HitCount, c_STATS ? 32'd2 : 32'd0);
    chk("stats_misses", MissCount, c_STATS ? 32'd1 : 32'd0);

    // Store hit
    wr_q.delete(); wrd_q.delete();
    do_op(1, 32'h0000_1104, 32'h1234_4321, st, rd);
    chk("store_stall_cycles", 32'(st), 32'd2);
    chk("store_writes", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) begin
      chk("store_addr", wr_q[0], 32'h0000_1104);
      chk("store_data", wrd_q[0], 32'h1234_4321);
    end
    do_op(0, 32'h0000_1104, 0, st, rd);
    chk("store_hit_readback", rd, 32'h1234_4321);
    chk("store_hit_stall", 32'(st), 32'd0);

    // Conflict eviction
    do_op(0, 32'h0000_1300, 0, st, rd);
    chk("conflict_stall", 32'(st), 32'd9);
    chk("conflict_data", rd, 32'hA5A5_B6A5);
    do_op(0, 32'h0000_1100, 0, st, rd);
    chk("refill_stall", 32'(st), 32'd9);
    chk("refill_data", rd, 32'hA5A5_B4A5);

    // Store miss, no allocate
    wr_q.delete(); wrd_q.delete();
    do_op(1, 32'h0000_2000, 32'hDEAD_BEEF, st, rd);
    chk("store_miss_writes", 32'(wr_q.size()), 32'd1);
    do_op(0, 32'h0000_2000, 0, st, rd);
    chk("no_allocate_stall", 32'(st), 32'd9);
    chk("no_allocate_data", rd, 32'h0000_2000 ^ c_K);
    go_idle(1);

    // Reset mid-fill
    fill_q.delete();
    @(posedge CLK); #1;
    MemRead = 1; ALUResult = 32'h0000_4000;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (fill_q.size() >= 2) break;
    end
    chk("midfill_acks_seen", 32'(fill_q.size()), 32'd2);
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("reset_memreq", 32'(MemReq), 32'd0);
    chk("reset_stall", 32'(Stall), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1; MemRead = 0;
    do_op(0, 32'h0000_4000, 0, st, rd);
    chk("post_reset_miss", 32'(st), 32'd9);
    chk("post_reset_data", rd, 32'h0000_4000 ^ c_K);

    // Randomized traffic
    rand_n = 1'b1;
    ack_noise = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = 32'h0000_1000 | (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 3)) << 4)
          | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      do_op(($urandom_range(0, 9) < 3), a, $urandom, st, rd);
      if ($urandom_range(0, 3) == 0) go_idle($urandom_range(1, 2));
    end
    go_idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
